// File: rtl/dram_write_collector.sv
// Collects ALU result vectors into a small FIFO and issues them as masked DRAM writes,
// one job per cfg handshake, with a one-cycle done pulse after the final write.
module dram_write_collector #(
  parameter int DBW   = 16,
  parameter int VSIZE = 32,
  parameter int ABW   = 32,
  parameter int NBW   = 20,
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 cfg_rdy,
  output logic                 cfg_ack,
  input  logic [ABW-1:0]       i_base,
  input  logic [ABW-1:0]       i_stride,
  input  logic [NBW-1:0]       i_nlane,
  input  logic                 dramwd_rdy,
  output logic                 dramwd_ack,
  input  logic [DBW*VSIZE-1:0] i_dramwd,
  output logic                 dramw_rdy,
  input  logic                 dramw_ack,
  output logic [ABW-1:0]       o_dramw_addr,
  output logic [DBW*VSIZE-1:0] o_dramw_data,
  output logic [VSIZE-1:0]     o_dramw_mask,
  output logic                 o_done_dval
);

  localparam int DW = DBW * VSIZE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = NBW + 1;
  localparam int LW = NBW + $clog2(VSIZE) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   nvec_q, nvec_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [NBW-1:0]  nlane_q, nlane_d;
  logic [ABW-1:0]  addr_q, addr_d;
  logic [ABW-1:0]  stride_q, stride_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;

  logic [DW-1:0]    data_mem [DEPTH];
  logic [VSIZE-1:0] mask_mem [DEPTH];

  logic            fifo_full, fifo_empty;
  logic            cfg_xfer, push, pop;
  logic [CW-1:0]   lanes_rounded;
  logic [LW-1:0]   lanes_done, lanes_left;
  logic [VSIZE-1:0] push_mask;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign dramw_rdy    = !fifo_empty;
  assign o_dramw_addr = addr_q;
  // Data and mask read as zero while nothing is pending, so the unreset memory never leaks out.
  assign o_dramw_data = fifo_empty ? '0 : data_mem[rd_ptr_q[PW-1:0]];
  assign o_dramw_mask = fifo_empty ? '0 : mask_mem[rd_ptr_q[PW-1:0]];
  assign o_done_dval  = (state_q == S_DONE);

  assign dramwd_ack = dramwd_rdy && (state_q == S_RUN) && !fifo_full && (in_cnt_q < nvec_q);
  assign cfg_xfer   = cfg_rdy && cfg_ack;
  assign push       = dramwd_ack;
  assign pop        = dramw_rdy && dramw_ack;

  // Lane count rounded up to whole vectors; one spare bit keeps the rounding add from overflowing.
  assign lanes_rounded = CW'(i_nlane) + CW'(VSIZE - 1);

  always_comb begin
    lanes_done = LW'(in_cnt_q) * LW'(VSIZE);
    lanes_left = LW'(nlane_q) - lanes_done;
    push_mask  = '0;
    for (int l = 0; l < VSIZE; l++) begin
      push_mask[l] = (LW'(l) < lanes_left);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cfg_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cfg_ack = cfg_rdy;
        if (cfg_rdy) state_d = S_RUN;
      end
      S_RUN:   if (pop && (out_cnt_q == nvec_q - CW'(1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nvec_d    = nvec_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    nlane_d   = nlane_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (cfg_xfer) begin
      nvec_d    = lanes_rounded / CW'(VSIZE);
      nlane_d   = i_nlane;
      addr_d    = i_base;
      stride_d  = i_stride;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (push) begin
        in_cnt_d = in_cnt_q + CW'(1);
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        out_cnt_d = out_cnt_q + CW'(1);
        rd_ptr_d  = rd_ptr_q + 1'b1;
        addr_d    = addr_q + stride_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      nvec_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      nlane_q   <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      nvec_q    <= nvec_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      nlane_q   <= nlane_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is carried entirely by the reset pointers.
  always_ff @(posedge i_clk) begin
    if (push) begin
      data_mem[wr_ptr_q[PW-1:0]] <= i_dramwd;
      mask_mem[wr_ptr_q[PW-1:0]] <= push_mask;
    end
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst && cfg_xfer) assert (i_nlane != '0);
  end
`endif

endmodule

// File: tb/tb_dram_write_collector.sv
// Self-checking bench: job table plus hand sequences, with a queue-based reference model
// that predicts handshakes, write order, addresses, lane masks and done pulses.
module tb_dram_write_collector;

  localparam int DBW   = 16;
  localparam int VSIZE = 32;
  localparam int ABW   = 32;
  localparam int NBW   = 20;
  localparam int DEPTH = 4;
  localparam int DW    = DBW * VSIZE;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b0;
  logic           cfg_rdy = 1'b0;
  logic           cfg_ack;
  logic [ABW-1:0] i_base = '0;
  logic [ABW-1:0] i_stride = '0;
  logic [NBW-1:0] i_nlane = '0;
  logic           dramwd_rdy = 1'b0;
  logic           dramwd_ack;
  logic [DW-1:0]  i_dramwd = '0;
  logic           dramw_rdy;
  logic           dramw_ack = 1'b0;
  logic [ABW-1:0] o_dramw_addr;
  logic [DW-1:0]  o_dramw_data;
  logic [VSIZE-1:0] o_dramw_mask;
  logic           o_done_dval;

  dram_write_collector #(.DBW(DBW), .VSIZE(VSIZE), .ABW(ABW), .NBW(NBW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .cfg_rdy(cfg_rdy), .cfg_ack(cfg_ack),
    .i_base(i_base), .i_stride(i_stride), .i_nlane(i_nlane),
    .dramwd_rdy(dramwd_rdy), .dramwd_ack(dramwd_ack), .i_dramwd(i_dramwd),
    .dramw_rdy(dramw_rdy), .dramw_ack(dramw_ack),
    .o_dramw_addr(o_dramw_addr), .o_dramw_data(o_dramw_data), .o_dramw_mask(o_dramw_mask),
    .o_done_dval(o_done_dval)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Lane l of vector k is written when its absolute lane index falls inside the job.
  function automatic logic [VSIZE-1:0] exp_mask(input int k, input int nl);
    logic [VSIZE-1:0] m;
    for (int l = 0; l < VSIZE; l++) m[l] = ((k * VSIZE + l) < nl);
    return m;
  endfunction

  // Reference model state
  logic [DW-1:0]  q[$];
  bit             m_active, m_done_now;
  logic [ABW-1:0] m_base, m_stride;
  int             m_nlane, m_nvec, m_in, m_out;
  int             cycle, job_writes, total_writes, total_wd, done_count;
  int             done_cycle, cfg_cycle, last_write_cycle;
  logic [ABW-1:0] last_addr;
  logic [VSIZE-1:0] last_mask;
  bit             last_cfg_xfer, last_wd_xfer;

  task automatic model_reset();
    q.delete();
    m_active = 0; m_done_now = 0; m_in = 0; m_out = 0;
    last_cfg_xfer = 0; last_wd_xfer = 0;
  endtask

  always @(negedge i_clk) begin
    bit cfg_x, wd_x, w_x, nxt_done, exp_wd;
    logic [ABW-1:0] ea;
    cycle++;
    if (i_rst) begin
      check("cfg_ack", cfg_ack, cfg_rdy && !m_active && !m_done_now);
      exp_wd = dramwd_rdy && m_active && (q.size() < DEPTH) && (m_in < m_nvec);
      check("dramwd_ack", dramwd_ack, exp_wd);
      check("dramw_rdy", dramw_rdy, q.size() != 0);
      if (dramw_rdy && q.size() != 0) begin
        ea = m_base + ABW'(m_out) * m_stride;
        check("dramw_addr", o_dramw_addr, ea);
        check("dramw_data", o_dramw_data, q[0]);
        check("dramw_mask", o_dramw_mask, exp_mask(m_out, m_nlane));
      end
      check("done_dval", o_done_dval, m_done_now);

      cfg_x = cfg_rdy && cfg_ack;
      wd_x  = dramwd_rdy && dramwd_ack;
      w_x   = dramw_rdy && dramw_ack;
      nxt_done = 0;
      if (w_x && q.size() != 0) begin
        last_addr = o_dramw_addr;
        last_mask = o_dramw_mask;
        job_writes++; total_writes++;
        last_write_cycle = cycle;
        q.delete(0);
        m_out++;
        if (m_out == m_nvec) begin
          m_active = 0;
          nxt_done = 1;
        end
      end
      if (wd_x) begin
        q.push_back(i_dramwd);
        m_in++; total_wd++;
      end
      if (cfg_x) begin
        m_base = i_base; m_stride = i_stride; m_nlane = int'(i_nlane);
        m_nvec = (m_nlane + VSIZE - 1) / VSIZE;
        m_in = 0; m_out = 0; q.delete();
        m_active = 1; job_writes = 0; cfg_cycle = cycle;
      end
      if (o_done_dval) begin
        done_count++;
        done_cycle = cycle;
      end
      m_done_now    = nxt_done;
      last_cfg_xfer = cfg_x;
      last_wd_xfer  = wd_x;
    end
  end

  // One clock of stimulus: producer keeps a raised vector stable until it is taken.
  task automatic drive_cycle(input int p_rdy, input int p_ack);
    @(posedge i_clk); #1;
    if (cfg_rdy && last_cfg_xfer) cfg_rdy = 1'b0;
    if (!dramwd_rdy || last_wd_xfer) begin
      dramwd_rdy = ($urandom_range(99) < p_rdy);
      if (dramwd_rdy) i_dramwd = rand_vec();
    end
    dramw_ack = ($urandom_range(99) < p_ack);
  endtask

  task automatic set_cfg(input logic [ABW-1:0] b, input logic [ABW-1:0] s, input int n);
    cfg_rdy = 1'b1; i_base = b; i_stride = s; i_nlane = NBW'(n);
  endtask

  task automatic run_job(input logic [ABW-1:0] b, input logic [ABW-1:0] s, input int n,
                         input int p_rdy, input int p_ack);
    int d0;
    d0 = done_count;
    set_cfg(b, s, n);
    for (int i = 0; i < 3000 && done_count == d0; i++) drive_cycle(p_rdy, p_ack);
    check("job_done_seen", done_count != d0, 1);
    repeat (3) drive_cycle(0, p_ack);
    check("one_done_pulse", done_count - d0, 1);
  endtask

  typedef struct {
    logic [ABW-1:0]   base;
    logic [ABW-1:0]   stride;
    int               nlane;
    int               p_rdy;
    int               p_ack;
    int               exp_nvec;
    logic [VSIZE-1:0] exp_last_mask;
    logic [ABW-1:0]   exp_last_addr;
  } job_vec_t;

  job_vec_t tbl[7];

  initial begin
    int d0, wd0, w0, dcyc, wcyc;
    bit b_sent;

    tbl[0] = '{32'h0000_0100, 32'h20,  64, 100, 100,  2, 32'hFFFF_FFFF, 32'h0000_0120};
    tbl[1] = '{32'h0000_2000, 32'h40,  40, 100, 100,  2, 32'h0000_00FF, 32'h0000_2040};
    tbl[2] = '{32'hFFFF_FFE0, 32'h20,  96, 100, 100,  3, 32'hFFFF_FFFF, 32'h0000_0020};
    tbl[3] = '{32'h0000_5000, 32'h10, 320,  60,  50, 10, 32'hFFFF_FFFF, 32'h0000_5090};
    tbl[4] = '{32'h0000_0000, 32'h08,   1,  70,  70,  1, 32'h0000_0001, 32'h0000_0000};
    tbl[5] = '{32'h0000_0300, 32'h01,  33, 100,  30,  2, 32'h0000_0001, 32'h0000_0301};
    tbl[6] = '{32'h0000_0ABC, 32'h100, 31,  50, 100,  1, 32'h7FFF_FFFF, 32'h0000_0ABC};

    model_reset();
    #2;
    check("rst_cfg_ack", cfg_ack, 0);
    check("rst_dramwd_ack", dramwd_ack, 0);
    check("rst_dramw_rdy", dramw_rdy, 0);
    check("rst_addr", o_dramw_addr, 0);
    check("rst_data", o_dramw_data, 0);
    check("rst_mask", o_dramw_mask, 0);
    check("rst_done", o_done_dval, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;

    // Back-to-back jobs: done one cycle after the last write, next cfg taken the cycle after done.
    d0 = done_count;
    b_sent = 0;
    set_cfg(32'h100, 32'h20, 64);
    for (int i = 0; i < 200 && done_count == d0; i++) begin
      drive_cycle(100, 100);
      if (!cfg_rdy && !b_sent) begin
        set_cfg(32'h400, 32'h20, 32);
        b_sent = 1;
      end
    end
    dcyc = done_cycle;
    wcyc = last_write_cycle;
    check("seq_done_seen", done_count - d0, 1);
    check("done_after_write", dcyc - wcyc, 1);
    for (int i = 0; i < 200 && done_count < d0 + 2; i++) drive_cycle(100, 100);
    check("cfg_after_done", cfg_cycle - dcyc, 1);
    check("seq_b_done", done_count - d0, 2);

    for (int t = 0; t < 7; t++) begin
      run_job(tbl[t].base, tbl[t].stride, tbl[t].nlane, tbl[t].p_rdy, tbl[t].p_ack);
      check($sformatf("tbl%0d_nvec", t), job_writes, tbl[t].exp_nvec);
      check($sformatf("tbl%0d_last_mask", t), last_mask, tbl[t].exp_last_mask);
      check($sformatf("tbl%0d_last_addr", t), last_addr, tbl[t].exp_last_addr);
    end

    // Write-side stall: only DEPTH vectors are taken, head stays put, then drains 1/cycle.
    wd0 = total_wd;
    d0  = done_count;
    set_cfg(32'h8000, 32'h20, 320);
    repeat (12) drive_cycle(100, 0);
    check("stall_acks", total_wd - wd0, DEPTH);
    check("stall_dramwd_ack", dramwd_ack, 0);
    check("stall_rdy", dramw_rdy, 1);
    check("stall_addr", o_dramw_addr, 32'h8000);
    w0 = total_writes;
    dramw_ack = 1'b1;
    repeat (10) drive_cycle(100, 100);
    check("drain_rate", total_writes - w0, 10);
    for (int i = 0; i < 50 && done_count == d0; i++) drive_cycle(100, 100);
    check("stall_job_done", done_count - d0, 1);
    check("stall_last_addr", last_addr, 32'h8000 + 9 * 32'h20);

    // Reset in the middle of a 5-vector job.
    set_cfg(32'h9000, 32'h20, 160);
    for (int i = 0; i < 40 && !(m_active && job_writes >= 2); i++) drive_cycle(100, 100);
    check("mid_job_progress", job_writes >= 2, 1);
    i_rst = 1'b0;
    model_reset();
    cfg_rdy = 1'b0; dramwd_rdy = 1'b0; dramw_ack = 1'b0;
    d0 = done_count;
    #1;
    check("abort_dramw_rdy", dramw_rdy, 0);
    check("abort_addr", o_dramw_addr, 0);
    check("abort_data", o_dramw_data, 0);
    check("abort_mask", o_dramw_mask, 0);
    check("abort_done", o_done_dval, 0);
    check("abort_dramwd_ack", dramwd_ack, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;
    repeat (3) drive_cycle(0, 100);
    check("abort_no_done", done_count - d0, 0);
    run_job(32'h9000, 32'h20, 160, 100, 100);
    check("post_rst_nvec", job_writes, 5);
    check("post_rst_last_addr", last_addr, 32'h9080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
